// File: rtl/score_keeper_pkg.sv
// Shared game constants and state encoding for the score keeper and its users.
// Top-level parameters default to these values and may be overridden per instance.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_FREEZE = 2'd2,
        ST_OVER   = 2'd3
    } game_state_e;

    localparam int DEF_INV_W          = 6;
    localparam int DEF_PLAYER_LIVES   = 3;
    localparam int DEF_MAX_LIVES      = 3;
    localparam int DEF_SCORE_W        = 10;
    localparam int DEF_MAX_SCORE      = 999;
    localparam int DEF_PTS_PER_HIT    = 1;
    localparam int DEF_WIN_SCORE      = 55;
    localparam int DEF_EXTRA_LIFE_PTS = 25;
    localparam int DEF_FREEZE_FRAMES  = 60;

endpackage

// File: rtl/score_keeper_hit_counter.sv
// Parametrised combinational popcount; also reused by the collision debug counters.
module hit_counter #(
    parameter int W = 6
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int CW = $clog2(W + 1);

    // Sum of set bits across the lane vector.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Score, lives and game-state tracker: saturating multi-hit scoring, extra lives,
// post-hit invulnerability, persistent high score and win/lose reporting.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int INV_W          = DEF_INV_W,
    parameter int PLAYER_LIVES   = DEF_PLAYER_LIVES,
    parameter int MAX_LIVES      = DEF_MAX_LIVES,
    parameter int SCORE_W        = DEF_SCORE_W,
    parameter int MAX_SCORE      = DEF_MAX_SCORE,
    parameter int PTS_PER_HIT    = DEF_PTS_PER_HIT,
    parameter int WIN_SCORE      = DEF_WIN_SCORE,
    parameter int EXTRA_LIFE_PTS = DEF_EXTRA_LIFE_PTS,
    parameter int FREEZE_FRAMES  = DEF_FREEZE_FRAMES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             frame,
    input  logic                             start,
    input  logic [INV_W-1:0]                 invader_collision,
    input  logic [1:0]                       player_collision,
    output logic [$clog2(MAX_LIVES+1)-1:0]   lives,
    output logic [SCORE_W-1:0]               score,
    output logic [SCORE_W-1:0]               high_score,
    output logic [1:0]                       state,
    output logic                             won,
    output logic                             done
);

    localparam int LIVES_W  = $clog2(MAX_LIVES + 1);
    localparam int HIT_W    = $clog2(INV_W + 1);
    localparam int SUM_W    = SCORE_W + $clog2(INV_W * PTS_PER_HIT + 1);
    // Threshold can run one step past the saturated score, hence the extra bit.
    localparam int TH_W     = SUM_W + 1;
    localparam int FRZ_W    = (FREEZE_FRAMES > 2) ? $clog2(FREEZE_FRAMES) : 1;
    localparam int FRZ_LOAD = (FREEZE_FRAMES > 0) ? FREEZE_FRAMES - 1 : 0;
    localparam bit BONUS_EN = (EXTRA_LIFE_PTS != 32'sd0);
    localparam bit FRZ_EN   = (FREEZE_FRAMES > 32'sd0);

    game_state_e          state_r;
    logic [SCORE_W-1:0]   score_r;
    logic [SCORE_W-1:0]   high_r;
    logic [LIVES_W-1:0]   lives_r;
    logic                 won_r;
    logic                 done_r;
    logic [FRZ_W-1:0]     frz_r;
    logic [TH_W-1:0]      thr_r;

    logic [HIT_W-1:0]     hits_s;
    logic [SUM_W-1:0]     sum_s;
    logic [SCORE_W-1:0]   new_score_s;
    logic                 bonus_s;
    logic                 hit_s;
    logic                 win_s;
    logic [LIVES_W-1:0]   net_lives_s;

    hit_counter #(
        .W (INV_W)
    ) u_hit_counter (
        .bits  (invader_collision),
        .count (hits_s)
    );

    // Per-frame score, bonus, hit and lives arithmetic.
    always_comb begin
        sum_s = SUM_W'(score_r) + SUM_W'(hits_s) * SUM_W'(PTS_PER_HIT);
        if (sum_s > SUM_W'(MAX_SCORE)) begin
            new_score_s = SCORE_W'(MAX_SCORE);
        end else begin
            new_score_s = sum_s[SCORE_W-1:0];
        end

        bonus_s = BONUS_EN && (TH_W'(new_score_s) >= thr_r);
        hit_s   = (player_collision != 2'b00) && (state_r == ST_PLAY);
        win_s   = (SUM_W'(new_score_s) >= SUM_W'(WIN_SCORE));

        // A bonus and a hit in the same frame cancel out.
        if (bonus_s && !hit_s) begin
            if (lives_r >= LIVES_W'(MAX_LIVES)) begin
                net_lives_s = LIVES_W'(MAX_LIVES);
            end else begin
                net_lives_s = lives_r + LIVES_W'(1);
            end
        end else if (hit_s && !bonus_s) begin
            if (lives_r == '0) begin
                net_lives_s = '0;
            end else begin
                net_lives_s = lives_r - LIVES_W'(1);
            end
        end else begin
            net_lives_s = lives_r;
        end
    end

    // Game FSM with registered score, lives, high score and win/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            score_r <= '0;
            high_r  <= '0;
            lives_r <= LIVES_W'(PLAYER_LIVES);
            won_r   <= 1'b0;
            done_r  <= 1'b0;
            frz_r   <= '0;
            thr_r   <= TH_W'(EXTRA_LIFE_PTS);
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_r <= ST_PLAY;
                        score_r <= '0;
                        lives_r <= LIVES_W'(PLAYER_LIVES);
                        won_r   <= 1'b0;
                        frz_r   <= '0;
                        thr_r   <= TH_W'(EXTRA_LIFE_PTS);
                    end
                end
                ST_PLAY, ST_FREEZE: begin
                    if (frame) begin
                        score_r <= new_score_s;
                        lives_r <= net_lives_s;
                        if (bonus_s) begin
                            thr_r <= thr_r + TH_W'(EXTRA_LIFE_PTS);
                        end
                        if (new_score_s > high_r) begin
                            high_r <= new_score_s;
                        end
                        if (win_s) begin
                            state_r <= ST_OVER;
                            won_r   <= 1'b1;
                            done_r  <= 1'b1;
                        end else if (net_lives_s == '0) begin
                            state_r <= ST_OVER;
                            won_r   <= 1'b0;
                            done_r  <= 1'b1;
                        end else if (hit_s && FRZ_EN) begin
                            state_r <= ST_FREEZE;
                            frz_r   <= FRZ_W'(FRZ_LOAD);
                        end else if (state_r == ST_FREEZE) begin
                            if (frz_r == '0) begin
                                state_r <= ST_PLAY;
                            end else begin
                                frz_r <= frz_r - FRZ_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign state      = state_r;
    assign score      = score_r;
    assign high_score = high_r;
    assign lives      = lives_r;
    assign won        = won_r;
    assign done       = done_r;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a default instance and a saturating/no-freeze instance
// share randomised stimulus and are checked every cycle against integer models.
module tb_score_keeper;

    localparam int M_LIVES = 3;
    localparam int M_MAXL  = 3;
    localparam int M_EXT   = 25;
    localparam int M_PTS   = 1;

    typedef struct {
        int st;
        int score;
        int lives;
        int high;
        int won;
        int done;
        int frz;
        int thr;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       frame = 1'b0;
    logic [5:0] inv = 6'd0;
    logic [1:0] pc = 2'd0;

    logic [1:0] lives1, lives2, state1, state2;
    logic [9:0] score1, score2, high1, high2;
    logic       won1, won2, done1, done2;

    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;
    mdl_t m1, m2;

    always #5 clk = ~clk;

    score_keeper u_dut (
        .clk (clk), .rst_n (rst_n), .frame (frame), .start (start),
        .invader_collision (inv), .player_collision (pc),
        .lives (lives1), .score (score1), .high_score (high1),
        .state (state1), .won (won1), .done (done1)
    );

    score_keeper #(.MAX_SCORE(10), .WIN_SCORE(999), .FREEZE_FRAMES(0)) u_sat (
        .clk (clk), .rst_n (rst_n), .frame (frame), .start (start),
        .invader_collision (inv), .player_collision (pc),
        .lives (lives2), .score (score2), .high_score (high2),
        .state (state2), .won (won2), .done (done2)
    );

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st = 0; m.score = 0; m.lives = M_LIVES; m.high = 0;
        m.won = 0; m.done = 0; m.frz = 0; m.thr = M_EXT;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit s, input bit f,
                                      input logic [5:0] iv, input logic [1:0] p,
                                      input int maxs, input int win, input int frzf);
        mdl_t n;
        int   sc;
        int   l;
        bit   hit;
        bit   bon;
        n = m;
        n.done = 0;
        if (m.st == 0 || m.st == 3) begin
            if (s) begin
                n.st = 1; n.score = 0; n.lives = M_LIVES; n.won = 0; n.thr = M_EXT;
            end
            return n;
        end
        if (!f) return n;
        sc = m.score + $countones(iv) * M_PTS;
        if (sc > maxs) sc = maxs;
        bon = (M_EXT != 0) && (sc >= m.thr);
        if (bon) n.thr = m.thr + M_EXT;
        hit = (p != 2'b00) && (m.st == 1);
        l = m.lives + int'(bon) - int'(hit);
        if (l < 0) l = 0;
        if (l > M_MAXL) l = M_MAXL;
        n.score = sc;
        n.lives = l;
        if (sc > m.high) n.high = sc;
        if (sc >= win) begin
            n.st = 3; n.won = 1; n.done = 1;
        end else if (l == 0) begin
            n.st = 3; n.won = 0; n.done = 1;
        end else if (hit && frzf > 0) begin
            n.st = 2; n.frz = frzf - 1;
        end else if (m.st == 2) begin
            if (m.frz == 0) n.st = 1;
            else n.frz = m.frz - 1;
        end
        return n;
    endfunction

    // Reference models advance on the same edges as the DUTs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= mdl_reset();
            m2 <= mdl_reset();
        end else begin
            m1 <= mdl_step(m1, start, frame, inv, pc, 999, 55, 60);
            m2 <= mdl_step(m2, start, frame, inv, pc, 10, 999, 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against their models.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("d1.state", int'(state1), m1.st);
            chk("d1.score", int'(score1), m1.score);
            chk("d1.lives", int'(lives1), m1.lives);
            chk("d1.high",  int'(high1),  m1.high);
            chk("d1.won",   int'(won1),   m1.won);
            chk("d1.done",  int'(done1),  m1.done);
            chk("d2.state", int'(state2), m2.st);
            chk("d2.score", int'(score2), m2.score);
            chk("d2.lives", int'(lives2), m2.lives);
            chk("d2.high",  int'(high2),  m2.high);
            chk("d2.won",   int'(won2),   m2.won);
            chk("d2.done",  int'(done2),  m2.done);
        end
    end

    task automatic tick(input bit s, input bit f, input logic [5:0] iv, input logic [1:0] p);
        start = s; frame = f; inv = iv; pc = p;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rst_state"}, int'(state1), 0);
        chk({tag, ".rst_score"}, int'(score1), 0);
        chk({tag, ".rst_lives"}, int'(lives1), 3);
        chk({tag, ".rst_high"},  int'(high1),  0);
        chk({tag, ".rst_won"},   int'(won1),   0);
        chk({tag, ".rst_done"},  int'(done1),  0);
        chk({tag, ".rst_score2"}, int'(score2), 0);
        chk({tag, ".rst_state2"}, int'(state2), 0);
    endtask

    // Mid-cycle asynchronous reset pulse, released on the next falling edge.
    task automatic async_reset(input bit check);
        #2 rst_n = 1'b0;
        #1;
        if (check) chk_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic hit_and_recover();
        tick(1'b0, 1'b1, 6'd0, 2'b01);
        repeat (60) tick(1'b0, 1'b1, 6'd0, 2'b00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("init");
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Saturation and zero-freeze behaviour on the second instance.
        tick(1'b1, 1'b0, 6'd0, 2'b00);
        chk("start_play", int'(state1), 1);
        repeat (3) tick(1'b0, 1'b1, 6'b111000, 2'b00);
        chk("sat_pre9", int'(score2), 9);
        tick(1'b0, 1'b1, 6'b111111, 2'b00);
        chk("sat_clamp", int'(score2), 10);
        chk("sat_high", int'(high2), 10);
        tick(1'b0, 1'b1, 6'd0, 2'b10);
        chk("nofrz_state", int'(state2), 1);
        chk("nofrz_lives", int'(lives2), 2);
        async_reset(1'b0);

        // Directed game on the default instance.
        tick(1'b1, 1'b0, 6'd0, 2'b00);
        tick(1'b0, 1'b1, 6'b101101, 2'b00);
        chk("first_score", int'(score1), 4);
        chk("first_state", int'(state1), 1);
        chk("first_high", int'(high1), 4);
        tick(1'b0, 1'b1, 6'd0, 2'b01);
        chk("hit_lives", int'(lives1), 2);
        chk("hit_freeze", int'(state1), 2);
        for (int i = 0; i < 59; i++) begin
            tick(1'b0, 1'b1, 6'd0, 2'b01);
            tick(1'b0, 1'b0, 6'd0, 2'b11);
        end
        chk("frz59_state", int'(state1), 2);
        chk("frz59_lives", int'(lives1), 2);
        tick(1'b0, 1'b1, 6'd0, 2'b01);
        chk("frz60_state", int'(state1), 1);
        chk("frz60_lives", int'(lives1), 2);

        repeat (3) tick(1'b0, 1'b1, 6'b111111, 2'b00);
        tick(1'b0, 1'b1, 6'b000011, 2'b00);
        chk("pre25_score", int'(score1), 24);
        chk("pre25_lives", int'(lives1), 2);
        tick(1'b0, 1'b1, 6'b000001, 2'b00);
        chk("bonus25_score", int'(score1), 25);
        chk("bonus25_lives", int'(lives1), 3);
        repeat (4) tick(1'b0, 1'b1, 6'b111111, 2'b00);
        tick(1'b0, 1'b1, 6'b100000, 2'b00);
        chk("bonus50_score", int'(score1), 50);
        chk("bonus50_clamp", int'(lives1), 3);

        hit_and_recover();
        hit_and_recover();
        chk("one_life", int'(lives1), 1);
        tick(1'b1, 1'b1, 6'b000001, 2'b00);
        chk("start_ignored_score", int'(score1), 51);
        chk("start_ignored_state", int'(state1), 1);
        tick(1'b0, 1'b1, 6'b001111, 2'b01);
        chk("win_state", int'(state1), 3);
        chk("win_won", int'(won1), 1);
        chk("win_done", int'(done1), 1);
        chk("win_high", int'(high1), 55);
        tick(1'b0, 1'b0, 6'd0, 2'b00);
        chk("done_pulse", int'(done1), 0);
        tick(1'b0, 1'b1, 6'b111111, 2'b01);
        chk("over_ignores", int'(score1), 55);

        tick(1'b1, 1'b0, 6'd0, 2'b00);
        chk("restart_score", int'(score1), 0);
        chk("restart_lives", int'(lives1), 3);
        chk("restart_high", int'(high1), 55);
        chk("restart_state", int'(state1), 1);
        hit_and_recover();
        hit_and_recover();
        tick(1'b0, 1'b1, 6'd0, 2'b01);
        chk("lose_state", int'(state1), 3);
        chk("lose_won", int'(won1), 0);
        chk("lose_done", int'(done1), 1);

        tick(1'b1, 1'b0, 6'd0, 2'b00);
        tick(1'b0, 1'b1, 6'b000111, 2'b00);
        tick(1'b0, 1'b1, 6'd0, 2'b01);
        repeat (5) tick(1'b0, 1'b1, 6'd0, 2'b00);
        chk("mid_frz_state", int'(state1), 2);
        async_reset(1'b1);

        // Randomised play with occasional mid-game resets.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                async_reset(1'b0);
            end else begin
                tick(($urandom_range(0, 29) == 0), bit'($urandom_range(0, 1)),
                     6'($urandom & $urandom),
                     ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
